// File: rtl/pc_seq.sv
// Program-sequencing unit: PC register, incrementer, jump/call/return mux and return stack.
// Define PC_SEQ_CIRC_EN to let a call on a full stack overwrite the oldest entry instead of dropping it.
module pc_seq #(
    parameter int          PC_W      = 10,
    parameter int          DEPTH     = 8,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     jump,
    input  logic                     call,
    input  logic                     ret,
    input  logic [PC_W-1:0]          target,
    output logic [PC_W-1:0]          pc,
    output logic [PC_W-1:0]          tos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf_err,
    output logic                     unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] mem [DEPTH];
    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, tos_val;
    logic [AW-1:0]   head_q, head_nxt, top_idx, wr_idx;
    logic [DW-1:0]   depth_q, depth_nxt;
    logic            ovf_q, ovf_nxt, unf_q, unf_nxt;
    logic            wr_en;
    logic            is_empty, is_full;

    assign pc_inc   = pc_q + 1'b1;
    assign top_idx  = head_q - 1'b1;
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(DEPTH));
    assign tos_val  = is_empty ? '0 : mem[top_idx];

    // Command decode; the write data is always the return address pc+1.
    always_comb begin
        pc_nxt    = pc_q;
        head_nxt  = head_q;
        depth_nxt = depth_q;
        wr_en     = 1'b0;
        wr_idx    = head_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        if (!stall) begin
            if (call && ret && !is_empty) begin
                // Swap: replace the top entry in place, depth unchanged.
                pc_nxt = tos_val;
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (ret && !call) begin
                if (!is_empty) begin
                    pc_nxt    = tos_val;
                    head_nxt  = top_idx;
                    depth_nxt = depth_q - DW'(1);
                end else begin
                    pc_nxt  = pc_inc;
                    unf_nxt = 1'b1;
                end
            end else if (call) begin
                pc_nxt = target;
                if (!is_full) begin
                    wr_en     = 1'b1;
                    head_nxt  = head_q + 1'b1;
                    depth_nxt = depth_q + DW'(1);
                end else begin
`ifdef PC_SEQ_CIRC_EN
                    // When full, head points at the oldest entry.
                    wr_en    = 1'b1;
                    head_nxt = head_q + 1'b1;
`else
                    ovf_nxt  = 1'b1;
`endif
                end
            end else if (jump) begin
                pc_nxt = target;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= PC_W'(RESET_VEC);
            head_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pc_q    <= pc_nxt;
            head_q  <= head_nxt;
            depth_q <= depth_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
            if (wr_en) begin
                mem[wr_idx] <= pc_inc;
            end
        end
    end

    assign pc      = pc_q;
    assign tos     = tos_val;
    assign depth   = depth_q;
    assign full    = is_full;
    assign empty   = is_empty;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed, table-driven bench for pc_seq (PC_W=10, DEPTH=8), plus hand-written overflow and reset sequences.
module tb_pc_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [9:0] target = '0;
    logic [9:0] pc, tos;
    logic [3:0] depth;
    logic       full, empty, ovf_err, unf_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       s, j, c, r;
        logic [9:0] tgt;
        logic [9:0] pc;
        logic [9:0] tos;
        logic [3:0] dep;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    pc_seq #(.PC_W(10), .DEPTH(8), .RESET_VEC(0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
        .target(target), .pc(pc), .tos(tos), .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic s, input logic j, input logic c, input logic r, input logic [9:0] t);
        stall = s; jump = j; call = c; ret = r; target = t;
    endtask

    task automatic add(input logic s, input logic j, input logic c, input logic r, input logic [9:0] t,
                       input logic [9:0] p, input logic [9:0] ts, input logic [3:0] d, input logic u);
        vec_t v;
        v.s = s; v.j = j; v.c = c; v.r = r; v.tgt = t;
        v.pc = p; v.tos = ts; v.dep = d; v.unf = u;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cmd(0, 0, 0, 0, 10'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [9:0] ra [9];

    initial begin
        //   s j c r  tgt     pc     tos    d  unf
        add(0,0,0,0, 10'h0,  10'h1,  10'h0, 0, 0);
        add(0,0,0,0, 10'h0,  10'h2,  10'h0, 0, 0);
        add(0,0,0,0, 10'h0,  10'h3,  10'h0, 0, 0);
        add(0,0,1,0, 10'h40, 10'h40, 10'h4, 1, 0);
        add(0,0,0,0, 10'h0,  10'h41, 10'h4, 1, 0);
        add(0,0,1,0, 10'h80, 10'h80, 10'h42,2, 0);
        add(0,0,0,1, 10'h0,  10'h42, 10'h4, 1, 0);
        add(0,0,0,1, 10'h0,  10'h4,  10'h0, 0, 0);
        add(0,1,0,0, 10'h10, 10'h10, 10'h0, 0, 0);
        add(0,0,0,1, 10'h0,  10'h11, 10'h0, 0, 1);
        add(0,0,1,0, 10'h20, 10'h20, 10'h12,1, 1);
        add(0,0,0,1, 10'h0,  10'h12, 10'h0, 0, 1);
        add(0,1,0,0, 10'h1F, 10'h1F, 10'h0, 0, 1);
        add(0,0,1,0, 10'h30, 10'h30, 10'h20,1, 1);
        add(0,0,1,1, 10'h0,  10'h20, 10'h31,1, 1);
        add(1,0,1,0, 10'h55, 10'h20, 10'h31,1, 1);
        add(0,1,1,0, 10'h7,  10'h7,  10'h21,2, 1);
        add(0,1,0,1, 10'h99, 10'h21, 10'h31,1, 1);
        add(0,0,0,1, 10'h0,  10'h31, 10'h0, 0, 1);
        add(0,0,1,1, 10'h50, 10'h50, 10'h32,1, 1);
        add(0,0,0,1, 10'h0,  10'h32, 10'h0, 0, 1);
        add(0,1,0,0, 10'h3FF,10'h3FF,10'h0, 0, 1);
        add(0,0,1,0, 10'h5,  10'h5,  10'h0, 1, 1);
        add(0,0,0,1, 10'h0,  10'h0,  10'h0, 0, 1);
        add(0,1,0,0, 10'h3FF,10'h3FF,10'h0, 0, 1);
        add(0,0,0,0, 10'h0,  10'h0,  10'h0, 0, 1);

        // Reset state.
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_tos", tos, 0);
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_unf", unf_err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Five idle cycles, then asynchronous reset mid-count.
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("idle_pc_%0d", i), pc, i);
            chk($sformatf("idle_empty_%0d", i), empty, 1);
        end
        #2 reset = 1'b0;
        #1 chk("async_rst_pc", pc, 0);
        #2 reset = 1'b1;

        foreach (vecs[k]) begin
            cmd(vecs[k].s, vecs[k].j, vecs[k].c, vecs[k].r, vecs[k].tgt);
            step();
            chk($sformatf("v%0d_pc", k), pc, vecs[k].pc);
            chk($sformatf("v%0d_tos", k), tos, vecs[k].tos);
            chk($sformatf("v%0d_depth", k), depth, vecs[k].dep);
            chk($sformatf("v%0d_empty", k), empty, vecs[k].dep == 0);
            chk($sformatf("v%0d_unf", k), unf_err, vecs[k].unf);
            chk($sformatf("v%0d_ovf", k), ovf_err, 0);
        end

        // Overflow: nine calls from pc=0, target of call i is 0x100+16*i.
        do_reset();
        ra[0] = 10'h001;
        for (int i = 1; i < 9; i++) ra[i] = 10'h100 + 10'(16 * (i - 1)) + 10'h1;
        for (int i = 0; i < 9; i++) begin
            cmd(0, 0, 1, 0, 10'h100 + 10'(16 * i));
            step();
            chk($sformatf("ovf_call_pc_%0d", i), pc, 10'h100 + 10'(16 * i));
        end
        cmd(0, 0, 0, 0, 10'h0);
        chk("ovf_depth", depth, 8);
        chk("ovf_full", full, 1);
        chk("ovf_empty", empty, 0);
`ifdef PC_SEQ_CIRC_EN
        chk("ovf_flag", ovf_err, 0);
        chk("ovf_tos", tos, ra[8]);
`else
        chk("ovf_flag", ovf_err, 1);
        chk("ovf_tos", tos, ra[7]);
`endif
        for (int k = 0; k < 8; k++) begin
            cmd(0, 0, 0, 1, 10'h0);
            step();
`ifdef PC_SEQ_CIRC_EN
            chk($sformatf("ovf_ret_pc_%0d", k), pc, ra[8-k]);
`else
            chk($sformatf("ovf_ret_pc_%0d", k), pc, ra[7-k]);
`endif
        end
        cmd(0, 0, 0, 0, 10'h0);
        chk("ovf_end_depth", depth, 0);
        chk("ovf_end_unf", unf_err, 0);
        chk("ovf_end_full", full, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
